// File: rtl/nukv_privacy_pkg.sv
// Shared constants for the privacy trailer framer: trailer tag, trailer field
// layout and FSM state encoding.
package nukv_privacy_pkg;

    localparam logic [15:0] TRAILER_MAGIC = 16'h5A17;

    localparam int CNT_LSB   = 0;
    localparam int CNT_W     = 16;
    localparam int SEQ_LSB   = 16;
    localparam int SEQ_W     = 32;
    localparam int MAGIC_LSB = 48;
    localparam int MAGIC_W   = 16;

    typedef enum logic {
        ST_PASS  = 1'b0,
        ST_TRAIL = 1'b1
    } state_t;

    // Low 64 bits of a trailer word; everything above bit 63 stays zero.
    function automatic logic [63:0] build_trailer(
        input logic [CNT_W-1:0]   cnt,
        input logic [SEQ_W-1:0]   seq,
        input logic [MAGIC_W-1:0] magic
    );
        logic [63:0] t;
        t = '0;
        t[CNT_LSB +: CNT_W]     = cnt;
        t[SEQ_LSB +: SEQ_W]     = seq;
        t[MAGIC_LSB +: MAGIC_W] = magic;
        return t;
    endfunction

endpackage

// File: rtl/nukv_privacy_trailer_framer.sv
// Passes value words through a single output register and appends one
// trailer word (count, sequence number, magic tag) after each value.
module nukv_privacy_trailer_framer
    import nukv_privacy_pkg::*;
#(
    parameter int          MEMORY_WIDTH  = 512,
    parameter logic [15:0] TRAILER_MAGIC = nukv_privacy_pkg::TRAILER_MAGIC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [MEMORY_WIDTH-1:0] input_data,
    input  logic                    input_valid,
    input  logic                    input_last,
    output logic                    input_ready,
    output logic [MEMORY_WIDTH-1:0] output_data,
    output logic                    output_valid,
    output logic                    output_last,
    input  logic                    output_ready,
    output logic [31:0]             frame_count
);

    state_t state_q, state_d;

    logic                    run_q;
    logic [CNT_W-1:0]        word_cnt_q;
    logic [31:0]             frame_count_q;
    logic [MEMORY_WIDTH-1:0] out_data_q;
    logic                    out_valid_q;
    logic                    out_last_q;

    logic                    slot_free;
    logic                    accept;
    logic                    load_trailer;
    logic [MEMORY_WIDTH-1:0] trailer_word;

    assign slot_free = !out_valid_q || output_ready;

    always_comb begin
        trailer_word       = '0;
        trailer_word[63:0] = build_trailer(word_cnt_q, frame_count_q, TRAILER_MAGIC);
    end

    // run_q holds input_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_PASS;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        input_ready  = 1'b0;
        accept       = 1'b0;
        load_trailer = 1'b0;
        case (state_q)
            ST_PASS: begin
                input_ready = run_q && slot_free;
                accept      = input_valid && input_ready;
                if (accept && input_last) state_d = ST_TRAIL;
            end
            ST_TRAIL: begin
                if (slot_free) begin
                    load_trailer = 1'b1;
                    state_d      = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // Count includes the last word, so the trailer reads it directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_cnt_q <= '0;
        end else if (load_trailer) begin
            word_cnt_q <= '0;
        end else if (accept && word_cnt_q != {CNT_W{1'b1}}) begin
            word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

    // Only written on trailer load so the counter holds between frames.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              frame_count_q <= '0;
        else if (load_trailer) frame_count_q <= frame_count_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_data_q  <= input_data;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
        end else if (load_trailer) begin
            out_data_q  <= trailer_word;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b1;
        end else if (slot_free) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign output_data  = out_data_q;
    assign output_valid = out_valid_q;
    assign output_last  = out_last_q;
    assign frame_count  = frame_count_q;

endmodule
